simple_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 12 +
 rtl/simple_adder.sv | 74 +++++++
 tb/tb_simple_adder.sv | 113 +++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared types and sizing for the bit-serial adder.
package adder_pkg;
    localparam int WIDTH = 2;
    localparam int SUM_W = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ADD  = 2'd2,
        SEND = 2'd3
    } state_t;
endpackage

// File: rtl/simple_adder.sv
// Bit-serial adder: operands shifted in MSB first, (WIDTH+1)-bit sum shifted out MSB first.
// First sum bit 3 cycles after en_i; no backpressure, en_i outside IDLE is ignored.
module simple_adder #(
    parameter int WIDTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic ina,
    input  logic inb,
    output logic en_o,
    output logic out
);
    import adder_pkg::*;

    localparam int SW = WIDTH + 1;
    localparam int CW = $clog2(SW + 1);

    state_t          state;
    logic [CW-1:0]   counter;
    logic [WIDTH-1:0] temp_a;
    logic [WIDTH-1:0] temp_b;
    logic [SW-1:0]   temp_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            counter  <= '0;
            temp_a   <= '0;
            temp_b   <= '0;
            temp_out <= '0;
            en_o     <= 1'b0;
            out      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    en_o <= 1'b0;
                    out  <= 1'b0;
                    if (en_i) begin
                        // Start from a clean register so a short previous load leaves nothing behind.
                        temp_a  <= {{(WIDTH-1){1'b0}}, ina};
                        temp_b  <= {{(WIDTH-1){1'b0}}, inb};
                        counter <= CW'(1);
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    temp_a  <= {temp_a[WIDTH-2:0], ina};
                    temp_b  <= {temp_b[WIDTH-2:0], inb};
                    counter <= counter + 1'b1;
                    if (counter == CW'(WIDTH - 1)) begin
                        state <= ADD;
                    end
                end
                ADD: begin
                    temp_out <= {1'b0, temp_a} + {1'b0, temp_b};
                    counter  <= CW'(SW);
                    state    <= SEND;
                end
                SEND: begin
                    out     <= temp_out[counter - 1'b1];
                    en_o    <= 1'b1;
                    counter <= counter - 1'b1;
                    if (counter == CW'(1)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_simple_adder.sv
// Directed and random operand checks for the bit-serial adder (WIDTH=2).
module tb_simple_adder;
    logic clk;
    logic rst;
    logic en_i;
    logic ina;
    logic inb;
    logic en_o;
    logic out;

    int checks = 0;
    int errors = 0;

    simple_adder #(.WIDTH(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .en_i (en_i),
        .ina  (ina),
        .inb  (inb),
        .en_o (en_o),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives en_i for the next edge and returns at the negedge
    // one cycle after the last en_o, ready for a back-to-back start.
    task automatic do_op(input logic [1:0] a, input logic [1:0] b, input bit spam, input string tag);
        logic [2:0] got;
        int         nen;
        int         first;
        int         expsum;
        got    = '0;
        nen    = 0;
        first  = -1;
        expsum = int'(a) + int'(b);
        en_i = 1'b1;
        ina  = a[1];
        inb  = b[1];
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (en_o) begin
                got = {got[1:0], out};
                if (first < 0) first = k;
                nen++;
            end
            if (k == 3) check({tag, "_temp_out"}, int'(dut.temp_out), expsum);
            if (k == 1) begin
                en_i = spam;
                ina  = a[0];
                inb  = b[0];
            end else begin
                en_i = spam && (k <= 5);
                ina  = 1'($urandom);
                inb  = 1'($urandom);
            end
        end
        en_i = 1'b0;
        check({tag, "_sum"}, int'(got), expsum);
        check({tag, "_en_cycles"}, nen, 3);
        check({tag, "_latency"}, first, 4);
        check({tag, "_en_tail"}, int'(en_o), 0);
    endtask

    initial begin
        rst  = 1'b1;
        en_i = 1'b0;
        ina  = 1'b0;
        inb  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_en_o", int'(en_o), 0);
        check("rst_out", int'(out), 0);
        check("rst_temp_out", int'(dut.temp_out), 0);
        rst = 1'b0;

        do_op(2'd3, 2'd3, 1'b0, "a3b3");
        do_op(2'd0, 2'd0, 1'b0, "a0b0");
        do_op(2'd2, 2'd1, 1'b0, "a2b1");
        do_op(2'd1, 2'd1, 1'b1, "spam_a1b1");
        do_op(2'd3, 2'd2, 1'b0, "b2b_a3b2");

        // Reset in the middle of SEND, held for two edges.
        en_i = 1'b1; ina = 1'b1; inb = 1'b1;
        @(negedge clk);
        en_i = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_en_o", int'(en_o), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_en_o", int'(en_o), 0);
        check("mid_rst_out", int'(out), 0);
        check("mid_rst_temp_out", int'(dut.temp_out), 0);
        @(negedge clk);
        rst = 1'b0;
        do_op(2'd1, 2'd2, 1'b0, "post_rst_a1b2");

        for (int i = 0; i < 100; i++) begin
            do_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
